load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
//  Sequential load path between the MEM stage and data memory, and the successor to the combinational load sizer.
//  Accepts one load request (address and size), issues word-aligned reads over a valid/ready memory port,
//  then byte-selects, merges and sign/zero-extends the data and returns it over a valid/ready response port.
//  Generalised to XLEN 32/64; optionally splits misaligned loads into two memory beats.
// PARAMETERS
//  XLEN    32  data width; 32 or 64; BYTES = XLEN/8, OFS_W = log2(BYTES)
//  ADDR_W  32  byte-address width
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  req_valid      in   1       load request valid
//  req_ready      out  1       unit can accept a request
//  req_addr       in   ADDR_W  byte address
//  req_size       in   3       000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 ld (XLEN=64), 110 lwu (XLEN=64)
//  mem_req_valid  out  1       memory read request
//  mem_req_ready  in   1       memory accepts the request
//  mem_addr       out  ADDR_W  word-aligned address (low OFS_W bits are 0)
//  mem_rsp_valid  in   1       read data valid; 1 outstanding read max, at least 1 cycle after acceptance
//  mem_rdata      in   XLEN    read data, little-endian lanes
//  rsp_valid      out  1       result valid
//  rsp_ready      in   1       consumer takes the result
//  rsp_data       out  XLEN    extended load result
//  rsp_err        out  1       illegal size, or misaligned access (no split)
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; mem_req_valid=0; mem_addr=0; rsp_valid=0; rsp_data=0; rsp_err=0.
//  - FSM: IDLE -> RD0 -> WAIT0 -> [RD1 -> WAIT1] -> RESP -> IDLE.
//    - req_ready = (state==IDLE). The request is captured on the edge where req_valid & req_ready.
//    - RDn: mem_req_valid=1; mem_addr is held stable until mem_req_ready; then go to WAITn.
//    - WAITn: capture mem_rdata on mem_rsp_valid. mem_rsp_valid is ignored in any other state.
//    - RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready; then go to IDLE.
//    - A new request is accepted no earlier than the cycle after the RESP handshake.
//  - Latency (memory with zero stalls, rsp_ready=1):
//    - Aligned load: accept at T, mem_req_valid at T+1, mem_rsp_valid at T+2, rsp_valid at T+3.
//    - Split load: rsp_valid at T+5.
//  - Size bytes: b=1, h=2, w=4, d=8. ofs = req_addr[OFS_W-1:0].
//    - Misaligned when ofs + size > BYTES (the access crosses a word boundary).
//  - Extraction: field = data >> (8*ofs), truncated to size. Signed sizes sign-extend from the field MSB;
//    lbu/lhu/lwu zero-extend. On XLEN=32, lw passes through unchanged.
//  - Illegal size (111; 101 or 110 on XLEN=32): no memory access; IDLE -> RESP directly, rsp_data=0, rsp_err=1.
//  - Second beat address = aligned_addr + BYTES, modulo 2^ADDR_W (wraps to 0 at the top of memory).
//  - rst_n low mid-operation: the unit returns to reset values at once; the transaction is dropped, not replayed.
//  - Any late mem_rsp_valid after reset is ignored.
// CONFIGURATION
//  LOAD_MISALIGN_SPLIT_EN defined:
//    - a misaligned load issues beat0 at aligned_addr and beat1 at aligned_addr+BYTES;
//    - merged = {beat1,beat0} >> (8*ofs), then extended; rsp_err=0.
//  Not defined:
//    - a misaligned load makes no memory access; IDLE -> RESP with rsp_data=0, rsp_err=1;
//    - RD1/WAIT1 states are not built.
// STRUCTURE
//  load_pkg: size encodings (SZ_LW..SZ_LWU), state enum, helper function size_bytes(size).
//  Sub-module load_extract (combinational): inputs 2*XLEN merged data, ofs, size; output extended XLEN result.
//    Used once, on the RESP-stage data.
// TESTING
//  1. XLEN=32, lb at addr 0x...3, mem_rdata=0x80_12_34_56 -> rsp_data=0xFFFFFF80, rsp_err=0, rsp_valid at T+3.
//  2. lhu at addr 0x...2, mem_rdata=0xBEEF_1234 -> rsp_data=0x0000BEEF. Same request as lh -> rsp_data=0xFFFFBEEF.
//  3. SPLIT_EN, lw at 0x1003: beat0 @0x1000=0xAABBCCDD, beat1 @0x1004=0x11223344 -> mem_addr 0x1000 then 0x1004;
//     rsp_data=0x223344AA.
//  4. No SPLIT_EN, same lw -> no mem_req_valid, rsp_data=0, rsp_err=1. req_size=111 -> rsp_err=1.
//  5. Backpressure: mem_req_ready low 3 cycles, rsp_ready low 2 cycles -> mem_addr/rsp_data stable;
//     req_ready=0 throughout.
//  6. rst_n pulsed in WAIT0, then mem_rsp_valid -> all outputs return to reset values, response ignored;
//     next lw completes normally.
//     SPLIT_EN, XLEN=32, lw at 0xFFFFFFFE -> second beat mem_addr=0x00000000.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load align unit: size encodings, FSM state
// encoding and small size helpers.
package load_pkg;

  localparam logic [2:0] SZ_LW  = 3'b000;
  localparam logic [2:0] SZ_LB  = 3'b001;
  localparam logic [2:0] SZ_LBU = 3'b010;
  localparam logic [2:0] SZ_LH  = 3'b011;
  localparam logic [2:0] SZ_LHU = 3'b100;
  localparam logic [2:0] SZ_LD  = 3'b101;
  localparam logic [2:0] SZ_LWU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_WAIT0 = 3'd2,
    S_RD1   = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  // Access width in bytes; 0 for the unused encoding.
  function automatic logic [3:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_LB, SZ_LBU:         size_bytes = 4'd1;
      SZ_LH, SZ_LHU:         size_bytes = 4'd2;
      SZ_LW, SZ_LWU:         size_bytes = 4'd4;
      SZ_LD:                 size_bytes = 4'd8;
      default:               size_bytes = 4'd0;
    endcase
  endfunction

  // 111 is never legal; ld/lwu only exist on a 64-bit datapath.
  function automatic logic size_legal(input logic [2:0] size, input int xlen);
    size_legal = (size != 3'b111) &&
                 !((xlen == 32) && ((size == SZ_LD) || (size == SZ_LWU)));
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte select and sign/zero extension of a (possibly two-beat)
// merged load word. Low beat sits in data_i[XLEN-1:0].
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFS_W = $clog2(XLEN/8)
) (
  input  logic [2*XLEN-1:0] data_i,
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [2:0]        size_i,
  output logic [XLEN-1:0]   res_o
);

  logic [XLEN-1:0] fld;

  // Shift the addressed byte down to lane 0; anything above XLEN is dropped.
  assign fld = XLEN'(data_i >> {ofs_i, 3'b000});

  // Truncate to the access size and extend to XLEN.
  always_comb begin
    res_o = '0;
    case (size_i)
      SZ_LB:   res_o = XLEN'($signed(fld[7:0]));
      SZ_LBU:  res_o = XLEN'(fld[7:0]);
      SZ_LH:   res_o = XLEN'($signed(fld[15:0]));
      SZ_LHU:  res_o = XLEN'(fld[15:0]);
      SZ_LW:   res_o = XLEN'($signed(fld[31:0]));
      SZ_LWU:  res_o = XLEN'(fld[31:0]);
      SZ_LD:   res_o = fld;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load path: accepts one load, issues word-aligned reads over a
// valid/ready memory port, then extracts/extends and returns the result.
// Build option: LOAD_MISALIGN_SPLIT_EN splits word-crossing loads into two
// memory beats; without it such loads complete immediately with an error.
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_size_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);

  localparam int BYTES = XLEN/8;
  localparam int OFS_W = $clog2(BYTES);

  state_e              state_q;
  logic                req_rdy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [OFS_W-1:0]    ofs_q;
  logic [2:0]          size_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                rsp_valid_q;
  logic [XLEN-1:0]     rsp_data_q;
  logic                rsp_err_q;

  logic [OFS_W-1:0]    req_ofs;
  logic [ADDR_W-1:0]   req_aligned;
  logic                req_legal;
  logic                req_cross;
  logic                req_noacc;
  logic                more_beats;
  logic [2*XLEN-1:0]   merged;
  logic [XLEN-1:0]     ext_data;

  assign req_ofs     = req_addr_i[OFS_W-1:0];
  assign req_aligned = {req_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign req_legal   = size_legal(req_size_i, XLEN);
  assign req_cross   = (int'(req_ofs) + int'(size_bytes(req_size_i))) > BYTES;

`ifdef LOAD_MISALIGN_SPLIT_EN
  logic            split_q;
  logic [XLEN-1:0] beat0_q;

  // Only an illegal size skips memory; crossing loads take two beats.
  assign req_noacc  = !req_legal;
  assign more_beats = split_q;
  // Second beat arrives in WAIT1 and forms the upper half of the merge.
  assign merged     = (state_q == S_WAIT1) ? {mem_rdata_i, beat0_q}
                                           : {{XLEN{1'b0}}, mem_rdata_i};

  // Remember whether this load needs a second beat, and hold beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_q <= 1'b0;
      beat0_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid_i)
        split_q <= req_legal && req_cross;
      if (state_q == S_WAIT0 && mem_rsp_valid_i)
        beat0_q <= mem_rdata_i;
    end
  end
`else
  // Crossing loads are rejected without touching memory.
  assign req_noacc  = !req_legal || req_cross;
  assign more_beats = 1'b0;
  assign merged     = {{XLEN{1'b0}}, mem_rdata_i};
`endif

  load_extract #(.XLEN(XLEN), .OFS_W(OFS_W)) u_extract (
    .data_i (merged),
    .ofs_i  (ofs_q),
    .size_i (size_q),
    .res_o  (ext_data)
  );

  // Main load FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      req_rdy_q       <= 1'b1;
      addr_q          <= '0;
      ofs_q           <= '0;
      size_q          <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_rdy_q <= 1'b0;
            addr_q    <= req_aligned;
            ofs_q     <= req_ofs;
            size_q    <= req_size_i;
            if (req_noacc) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q         <= S_RD0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= req_aligned;
            end
          end
        end
        S_RD0: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (mem_rsp_valid_i) begin
            if (more_beats) begin
              // Wraps modulo 2^ADDR_W at the top of memory.
              state_q         <= S_RD1;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= addr_q + ADDR_W'(BYTES);
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= ext_data;
              rsp_err_q   <= 1'b0;
            end
          end
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        S_RD1: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (mem_rsp_valid_i) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ext_data;
            rsp_err_q   <= 1'b0;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            req_rdy_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q         <= S_IDLE;
          req_rdy_q       <= 1'b1;
          mem_req_valid_q <= 1'b0;
          rsp_valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o     = req_rdy_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed, table-driven bench for load_align_unit (XLEN=32). Expectations
// follow the LOAD_MISALIGN_SPLIT_EN build option when it is defined.
module tb_load_align_unit;

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_size_i      (req_size),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_addr_o      (mem_addr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rdata_i     (mem_rdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_err_o       (rsp_err)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] w0, w1;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_beats;
    logic [31:0] exp_a0, exp_a1;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] w0, w1, d, input logic e, input int lat,
                              input int nb, input logic [31:0] a0, a1);
    vec_t v;
    v.name = n; v.addr = a; v.size = s; v.w0 = w0; v.w1 = w1; v.exp_data = d;
    v.exp_err = e; v.exp_lat = lat; v.exp_beats = nb; v.exp_a0 = a0; v.exp_a1 = a1;
    return v;
  endfunction

  // One full transaction with a cycle-level memory/consumer model.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] w0, w1, input int mstall, input int rstall,
                         output logic [31:0] data, output logic err, output int lat,
                         output int beats, output logic [31:0] a0, output logic [31:0] a1,
                         output bit busy_ok, output bit stable_ok);
    int k; bit pend, done, mwait, rwait, seen;
    logic [31:0] pdata, pa, pd; logic pe;
    lat = -1; beats = 0; a0 = '0; a1 = '0; busy_ok = 1; stable_ok = 1;
    pend = 0; done = 0; mwait = 0; rwait = 0; seen = 0; data = '0; err = 1'b0;
    pdata = '0; pa = '0; pd = '0; pe = 1'b0;
    @(negedge clk);
    if (!req_ready) busy_ok = 0;
    req_valid = 1'b1; req_addr = addr; req_size = size;
    @(posedge clk);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
      if (req_ready) busy_ok = 0;
      mem_rsp_valid = pend;
      mem_rdata = pend ? pdata : 32'h0;
      pend = 0;
      if (mem_req_valid) begin
        if (mwait && mem_addr !== pa) stable_ok = 0;
        if (!mwait) begin
          beats++;
          if (beats == 1) a0 = mem_addr; else a1 = mem_addr;
        end
        pa = mem_addr;
        if (mstall > 0) begin mem_req_ready = 1'b0; mstall--; mwait = 1; end
        else begin
          mem_req_ready = 1'b1; mwait = 0; pend = 1;
          pdata = (beats == 1) ? w0 : w1;
        end
      end else mem_req_ready = 1'b0;
      if (rsp_valid) begin
        if (!seen) begin lat = k; seen = 1; end
        if (rwait && (rsp_data !== pd || rsp_err !== pe)) stable_ok = 0;
        pd = rsp_data; pe = rsp_err;
        if (rstall > 0) begin rsp_ready = 1'b0; rstall--; rwait = 1; end
        else begin rsp_ready = 1'b1; data = rsp_data; err = rsp_err; done = 1; end
      end else rsp_ready = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    if (!done) lat = -1;
  endtask

  task automatic run_vec(input vec_t v, input int mstall, input int rstall);
    logic [31:0] d, a0, a1; logic e; int lat, nb; bit bok, sok;
    do_load(v.addr, v.size, v.w0, v.w1, mstall, rstall, d, e, lat, nb, a0, a1, bok, sok);
    chk({v.name, ".data"}, d, v.exp_data);
    chk({v.name, ".err"}, e, v.exp_err);
    chk({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    chk({v.name, ".beats"}, 64'(nb), 64'(v.exp_beats));
    if (v.exp_beats > 0) chk({v.name, ".addr0"}, a0, v.exp_a0);
    if (v.exp_beats > 1) chk({v.name, ".addr1"}, a1, v.exp_a1);
    chk({v.name, ".req_ready_low"}, bok, 1'b1);
    chk({v.name, ".stable"}, sok, 1'b1);
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, ".req_ready"}, req_ready, 1'b1);
    chk({n, ".mem_req_valid"}, mem_req_valid, 1'b0);
    chk({n, ".mem_addr"}, mem_addr, 32'h0);
    chk({n, ".rsp_valid"}, rsp_valid, 1'b0);
    chk({n, ".rsp_data"}, rsp_data, 32'h0);
    chk({n, ".rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Aligned and in-word loads: latency 3, one beat at the word address.
    vt.push_back(mk("lb_ofs3",  32'h0000_0103, 3'b001, 32'h8012_3456, 0, 32'hFFFF_FF80, 0, 3, 1, 32'h100, 0));
    vt.push_back(mk("lhu_ofs2", 32'h0000_0102, 3'b100, 32'hBEEF_1234, 0, 32'h0000_BEEF, 0, 3, 1, 32'h100, 0));
    vt.push_back(mk("lh_ofs2",  32'h0000_0102, 3'b011, 32'hBEEF_1234, 0, 32'hFFFF_BEEF, 0, 3, 1, 32'h100, 0));
    vt.push_back(mk("lw_al",    32'h0000_0100, 3'b000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 3, 1, 32'h100, 0));
    vt.push_back(mk("lbu_ofs1", 32'h0000_0201, 3'b010, 32'h1234_F656, 0, 32'h0000_00F6, 0, 3, 1, 32'h200, 0));
    vt.push_back(mk("lb_ofs1",  32'h0000_0201, 3'b001, 32'h1234_F656, 0, 32'hFFFF_FFF6, 0, 3, 1, 32'h200, 0));
    vt.push_back(mk("lh_pos",   32'h0000_0300, 3'b011, 32'h0001_7FFF, 0, 32'h0000_7FFF, 0, 3, 1, 32'h300, 0));
    // Illegal sizes: no memory access, straight to RESP.
    vt.push_back(mk("sz111",    32'h0000_0100, 3'b111, 0, 0, 32'h0, 1, 1, 0, 0, 0));
    vt.push_back(mk("ld_x32",   32'h0000_0100, 3'b101, 0, 0, 32'h0, 1, 1, 0, 0, 0));
    vt.push_back(mk("lwu_x32",  32'h0000_0100, 3'b110, 0, 0, 32'h0, 1, 1, 0, 0, 0));
    // Word-crossing loads.
    if (SPLIT) begin
      vt.push_back(mk("lw_x1003", 32'h0000_1003, 3'b000, 32'hAABB_CCDD, 32'h1122_3344,
                      32'h2233_44AA, 0, 5, 2, 32'h1000, 32'h1004));
      vt.push_back(mk("lh_x1003", 32'h0000_1003, 3'b011, 32'hAABB_CCDD, 32'h1122_3344,
                      32'h0000_44AA, 0, 5, 2, 32'h1000, 32'h1004));
    end else begin
      vt.push_back(mk("lw_x1003", 32'h0000_1003, 3'b000, 32'hAABB_CCDD, 32'h1122_3344,
                      32'h0, 1, 1, 0, 0, 0));
      vt.push_back(mk("lh_x1003", 32'h0000_1003, 3'b011, 32'hAABB_CCDD, 32'h1122_3344,
                      32'h0, 1, 1, 0, 0, 0));
    end

    foreach (vt[i]) run_vec(vt[i], 0, 0);

    // Backpressure: 3 stalled request cycles, 2 stalled response cycles.
    v = mk("bp_lw", 32'h0000_0400, 3'b000, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 6, 1, 32'h400, 0);
    run_vec(v, 3, 2);

    // Reset pulse while waiting for read data; the late response is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0500; req_size = 3'b000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.mem_req_valid_before", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_late_rsp");
    v = mk("post_rst_lw", 32'h0000_0600, 3'b000, 32'h0BAD_CAFE, 0, 32'h0BAD_CAFE, 0, 3, 1, 32'h600, 0);
    run_vec(v, 0, 0);

`ifdef LOAD_MISALIGN_SPLIT_EN
    // Second beat wraps to address 0 at the top of memory.
    v = mk("wrap_lw", 32'hFFFF_FFFE, 3'b000, 32'h4433_2211, 32'h8877_6655,
           32'h6655_4433, 0, 5, 2, 32'hFFFF_FFFC, 32'h0000_0000);
    run_vec(v, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
